d_sequencer: RTL and testbench

D_SEQUENCER -- requirements
Module: d_sequencer

---
 rtl/d_sequencer_pkg.sv | 23 ++
 rtl/d_sequencer_if.sv | 36 +++
 rtl/d_sequencer_retry_cnt.sv | 39 +++
 rtl/d_sequencer.sv | 116 +++++++++++
 tb/tb_d_sequencer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/d_sequencer_pkg.sv
// d_sequencer_pkg -- shared SD definitions for the transceiver blocks.
//   SD_MAX_RETRY : default number of d_driver re-runs per block after a CRC failure
//   seq_state_t  : d_sequencer FSM state encoding
//   retry_cnt_w  : width needed to hold a retry count of 0..max_retry
package d_sequencer_pkg;

  localparam int SD_MAX_RETRY = 3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DRV_GO    = 3'd1,
    S_DRV_WAIT  = 3'd2,
    S_PROC_GO   = 3'd3,
    S_PROC_WAIT = 3'd4,
    S_NEXT      = 3'd5,
    S_FIN       = 3'd6
  } seq_state_t;

  function automatic int retry_cnt_w(input int max_retry);
    return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
  endfunction

endpackage

// File: rtl/d_sequencer_if.sv
// d_sequencer_if -- job control and d_driver / processing-core handshake bundle.
//   istart, inblocks        : job request (inblocks sampled with the accepted istart)
//   ostart_d, idone_d,
//   icrc_fail_d             : d_driver start / done / CRC-failure (valid with idone_d)
//   ostart_p, idone_p       : processing-core start / done
//   obuf_sel, oblk_idx      : buffer owner (0 = d_driver, 1 = core) and current block
//   obusy, odone, oerr      : job in progress, job-complete pulse, sticky error
// Handshake semantics: every start/done signal is a single-cycle pulse, there is
// no ready/backpressure; a pulse is consumed only by the state waiting for it and
// is otherwise dropped.
interface d_sequencer_if #(
  parameter int BLK_W = 16
);
  logic             istart;
  logic [BLK_W-1:0] inblocks;
  logic             ostart_d;
  logic             idone_d;
  logic             icrc_fail_d;
  logic             ostart_p;
  logic             idone_p;
  logic             obuf_sel;
  logic [BLK_W-1:0] oblk_idx;
  logic             obusy;
  logic             odone;
  logic             oerr;

  modport slave (
    input  istart, inblocks, idone_d, icrc_fail_d, idone_p,
    output ostart_d, ostart_p, obuf_sel, oblk_idx, obusy, odone, oerr
  );

  modport master (
    output istart, inblocks, idone_d, icrc_fail_d, idone_p,
    input  ostart_d, ostart_p, obuf_sel, oblk_idx, obusy, odone, oerr
  );
endinterface

// File: rtl/d_sequencer_retry_cnt.sv
// d_retry_cnt -- saturating per-block retry counter with limit compare.
//   iclk, irst   : clock, asynchronous active-low reset
//   i_clr        : clear the count (new job or successful d_driver run)
//   i_inc        : count one CRC failure (holds once the limit is reached)
//   o_cnt        : current retry count
//   o_at_limit   : count equals MAX_RETRY; the next failure is fatal
module d_retry_cnt
  import d_sequencer_pkg::*;
#(
  parameter  int MAX_RETRY = SD_MAX_RETRY,
  localparam int CW        = retry_cnt_w(MAX_RETRY)
) (
  input  logic          iclk,
  input  logic          irst,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [CW-1:0] o_cnt,
  output logic          o_at_limit
);

  logic [CW-1:0] r_cnt;
  logic          w_at_limit;

  assign w_at_limit = (r_cnt == CW'(MAX_RETRY));

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_at_limit) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_cnt      = r_cnt;
  assign o_at_limit = w_at_limit;

endmodule

// File: rtl/d_sequencer.sv
// d_sequencer -- multi-block job sequencer: for each block, run the d_driver
// (retrying on CRC failure up to MAX_RETRY times), then hand the buffer to the
// processing core, then advance to the next block.
//   iclk, irst : clock, asynchronous active-low reset
//   bus        : d_sequencer_if slave (job control, d_driver and core handshakes)
//   odbg_state : current FSM state, for observation only
module d_sequencer
  import d_sequencer_pkg::*;
#(
  parameter int MAX_RETRY = SD_MAX_RETRY,
  parameter int BLK_W     = 16
) (
  input  logic        iclk,
  input  logic        irst,
  d_sequencer_if.slave bus,
  output seq_state_t  odbg_state
);

  localparam int CW = retry_cnt_w(MAX_RETRY);

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic [BLK_W-1:0] r_nblocks;
  logic [BLK_W-1:0] r_blk_idx;
  logic             r_err;
  logic             r_zero_done;

  logic             w_accept;
  logic             w_zero_req;
  logic             w_drv_ok;
  logic             w_drv_fail;
  logic             w_last;
  logic [CW-1:0]    w_retry_cnt;
  logic             w_retry_at_limit;

  assign w_accept   = bus.istart && (r_state == S_IDLE) && (bus.inblocks != '0);
  assign w_zero_req = bus.istart && (r_state == S_IDLE) && (bus.inblocks == '0);
  assign w_drv_ok   = (r_state == S_DRV_WAIT) && bus.idone_d && !bus.icrc_fail_d;
  assign w_drv_fail = (r_state == S_DRV_WAIT) && bus.idone_d &&  bus.icrc_fail_d;
  // r_nblocks is never 0 while a job runs, so the subtraction cannot wrap.
  assign w_last     = (r_blk_idx == (r_nblocks - BLK_W'(1)));

  d_retry_cnt #(
    .MAX_RETRY (MAX_RETRY)
  ) u_retry (
    .iclk       (iclk),
    .irst       (irst),
    .i_clr      (w_accept || w_drv_ok),
    .i_inc      (w_drv_fail),
    .o_cnt      (w_retry_cnt),
    .o_at_limit (w_retry_at_limit)
  );

  // State register
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:      if (w_accept) w_next = S_DRV_GO;
      S_DRV_GO:    w_next = S_DRV_WAIT;
      S_DRV_WAIT: begin
        if (w_drv_ok)                          w_next = S_PROC_GO;
        else if (w_drv_fail && w_retry_at_limit) w_next = S_FIN;
        else if (w_drv_fail)                   w_next = S_DRV_GO;
      end
      S_PROC_GO:   w_next = S_PROC_WAIT;
      S_PROC_WAIT: if (bus.idone_p) w_next = S_NEXT;
      S_NEXT:      w_next = w_last ? S_FIN : S_DRV_GO;
      S_FIN:       w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Job datapath: latched block count, block index, sticky error, zero-job done
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      r_nblocks   <= '0;
      r_blk_idx   <= '0;
      r_err       <= 1'b0;
      r_zero_done <= 1'b0;
    end else begin
      r_zero_done <= w_zero_req;
      if (w_accept) begin
        r_nblocks <= bus.inblocks;
        r_blk_idx <= '0;
        r_err     <= 1'b0;
      end else begin
        if ((r_state == S_NEXT) && !w_last) r_blk_idx <= r_blk_idx + BLK_W'(1);
        if (w_drv_fail && w_retry_at_limit) r_err     <= 1'b1;
      end
    end
  end

  // Outputs are decoded from registered state only, so they are clean pulses.
  // The core owns the buffer exactly from PROC_GO until it reports done.
  always_comb begin
    bus.ostart_d = (r_state == S_DRV_GO);
    bus.ostart_p = (r_state == S_PROC_GO);
    bus.obuf_sel = (r_state == S_PROC_GO) || (r_state == S_PROC_WAIT);
    bus.obusy    = (r_state != S_IDLE);
    bus.odone    = (r_state == S_FIN) || r_zero_done;
    bus.oblk_idx = r_blk_idx;
    bus.oerr     = r_err;
    odbg_state   = r_state;
  end

  // Retry count is only used through its limit flag here.
  logic w_unused;
  assign w_unused = ^w_retry_cnt;

endmodule

// File: tb/tb_d_sequencer.sv
// tb_d_sequencer -- directed bench for d_sequencer: a table of jobs run against
// a cycle-stepped d_driver/core responder, plus hand-written sequences for reset,
// zero-block jobs, ignored inputs and mid-job reset.
module tb_d_sequencer;
  import d_sequencer_pkg::*;

  localparam int BW = 16;

  // ---------------- clock / reset ----------------
  logic       iclk = 1'b0;
  logic       irst = 1'b0;
  seq_state_t dbg_state;

  always #5 iclk = ~iclk;

  d_sequencer_if #(.BLK_W(BW)) sif ();

  d_sequencer #(
    .MAX_RETRY (3),
    .BLK_W     (BW)
  ) dut (
    .iclk       (iclk),
    .irst       (irst),
    .bus        (sif.slave),
    .odbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [BW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {10'd0, sif.ostart_d, sif.ostart_p, sif.obuf_sel, sif.obusy,
            sif.odone, sif.oerr, sif.oblk_idx};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  task automatic clear_inputs();
    sif.istart      = 1'b0;
    sif.idone_d     = 1'b0;
    sif.icrc_fail_d = 1'b0;
    sif.idone_p     = 1'b0;
  endtask

  task automatic start_job(input logic [BW-1:0] nb);
    sif.istart   = 1'b1;
    sif.inblocks = nb;
    step();
    sif.istart   = 1'b0;
  endtask

  typedef struct {
    logic [BW-1:0] nb;
    int            fail_n;   // number of leading idone_d pulses flagged as CRC failures
    int            exp_sd;
    int            exp_sp;
    logic          exp_err;
    logic [BW-1:0] exp_idx;  // oblk_idx during odone
  } vec_t;

  // Runs one job with a responder: idone_d 3 cycles after each ostart_d,
  // idone_p 6 cycles after each ostart_p.
  task automatic apply_vec(input vec_t v, input string tag);
    int td = -1, tp = -1, dn = 0, sd = 0, sp = 0, bad = 0, last_p = -100;
    bit done_seen = 0;
    logic err_d = 1'b0;
    logic [BW-1:0] idx_d = '0;

    exp_q.delete();
    for (int k = 0; k < v.exp_sp; k++) exp_q.push_back(BW'(k));

    start_job(v.nb);
    check({tag, " accept_latency"}, {31'd0, sif.ostart_d}, 32'd1);
    check({tag, " oerr_cleared"},   {31'd0, sif.oerr},     32'd0);
    check({tag, " first_idx"},      {16'd0, sif.oblk_idx}, 32'd0);

    for (int c = 0; c < 3000; c++) begin
      sif.idone_d     = 1'b0;
      sif.idone_p     = 1'b0;
      sif.icrc_fail_d = 1'b0;
      if (sif.odone) begin
        done_seen = 1;
        err_d     = sif.oerr;
        idx_d     = sif.oblk_idx;
        break;
      end
      if (sif.ostart_d) begin
        sd++;
        if (sif.obuf_sel !== 1'b0) bad++;
        if (last_p >= 0 && (c - last_p) != 2) bad++;
        last_p = -1;
        td = 2;
      end
      if (sif.ostart_p) begin
        sp++;
        if (sif.obuf_sel !== 1'b1) bad++;
        if (exp_q.size() > 0) check({tag, " proc_idx"}, {16'd0, sif.oblk_idx}, {16'd0, exp_q.pop_front()});
        else bad++;
        tp = 5;
      end
      if (td == 0) begin
        sif.idone_d     = 1'b1;
        sif.icrc_fail_d = (dn < v.fail_n);
        dn++;
      end
      if (tp == 0) begin
        sif.idone_p = 1'b1;
        last_p = c;
      end
      if (td >= 0) td--;
      if (tp >= 0) tp--;
      step();
    end
    clear_inputs();

    check({tag, " done_seen"},   {31'd0, done_seen}, 32'd1);
    check({tag, " ostart_d_cnt"}, sd, v.exp_sd);
    check({tag, " ostart_p_cnt"}, sp, v.exp_sp);
    check({tag, " oerr"},         {31'd0, err_d}, {31'd0, v.exp_err});
    check({tag, " done_idx"},     {16'd0, idx_d}, {16'd0, v.exp_idx});
    check({tag, " protocol_bad"}, bad, 0);
    check({tag, " queue_left"},   exp_q.size(), 0);
    step();
    check({tag, " idle_after"},   {31'd0, sif.obusy}, 32'd0);
    check({tag, " odone_single"}, {31'd0, sif.odone}, 32'd0);
  endtask

  vec_t vecs[6];

  // ---------------- test ----------------
  initial begin
    clear_inputs();
    sif.inblocks = '0;

    vecs[0] = '{nb: 16'd3, fail_n: 0,   exp_sd: 3, exp_sp: 3, exp_err: 1'b0, exp_idx: 16'd2};
    vecs[1] = '{nb: 16'd1, fail_n: 2,   exp_sd: 3, exp_sp: 1, exp_err: 1'b0, exp_idx: 16'd0};
    vecs[2] = '{nb: 16'd2, fail_n: 100, exp_sd: 4, exp_sp: 0, exp_err: 1'b1, exp_idx: 16'd0};
    vecs[3] = '{nb: 16'd4, fail_n: 1,   exp_sd: 5, exp_sp: 4, exp_err: 1'b0, exp_idx: 16'd3};
    vecs[4] = '{nb: 16'd2, fail_n: 3,   exp_sd: 5, exp_sp: 2, exp_err: 1'b0, exp_idx: 16'd1};
    vecs[5] = '{nb: 16'd1, fail_n: 4,   exp_sd: 4, exp_sp: 0, exp_err: 1'b1, exp_idx: 16'd0};

    // Reset state
    step();
    step();
    check("reset_outputs", all_outs(), 32'd0);
    check("reset_state",   {29'd0, dbg_state}, {29'd0, S_IDLE});
    irst = 1'b1;
    step();
    check("post_reset_no_start", {31'd0, sif.ostart_d}, 32'd0);
    step();

    // Zero-block job: odone next cycle, nothing started, stays idle
    start_job(16'd0);
    check("zero_odone",  {31'd0, sif.odone}, 32'd1);
    check("zero_obusy",  {31'd0, sif.obusy}, 32'd0);
    check("zero_nostart", {30'd0, sif.ostart_d, sif.ostart_p}, 32'd0);
    step();
    check("zero_odone_single", {31'd0, sif.odone}, 32'd0);
    check("zero_state", {29'd0, dbg_state}, {29'd0, S_IDLE});

    // Table of jobs
    for (int i = 0; i < 6; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Spurious / simultaneous done pulses and istart during PROC_WAIT
    start_job(16'd1);
    check("sp_drv_go", {31'd0, sif.ostart_d}, 32'd1);
    step();
    check("sp_drv_wait", {29'd0, dbg_state}, {29'd0, S_DRV_WAIT});
    sif.idone_p = 1'b1;
    step();
    sif.idone_p = 1'b0;
    check("sp_idone_p_ignored", {29'd0, dbg_state}, {29'd0, S_DRV_WAIT});
    check("sp_bufsel_drv", {31'd0, sif.obuf_sel}, 32'd0);
    sif.idone_d = 1'b1;
    sif.idone_p = 1'b1;
    step();
    clear_inputs();
    check("sp_both_done_state", {29'd0, dbg_state}, {29'd0, S_PROC_GO});
    check("sp_ostart_p", {31'd0, sif.ostart_p}, 32'd1);
    check("sp_bufsel_proc", {31'd0, sif.obuf_sel}, 32'd1);
    step();
    sif.istart      = 1'b1;
    sif.inblocks    = 16'd5;
    sif.idone_d     = 1'b1;
    sif.icrc_fail_d = 1'b1;
    step();
    clear_inputs();
    check("sp_ignored_state", {29'd0, dbg_state}, {29'd0, S_PROC_WAIT});
    check("sp_ignored_bufsel", {31'd0, sif.obuf_sel}, 32'd1);
    check("sp_ignored_idx", {16'd0, sif.oblk_idx}, 32'd0);
    check("sp_ignored_nostart", {31'd0, sif.ostart_d}, 32'd0);
    sif.idone_p = 1'b1;
    step();
    sif.idone_p = 1'b0;
    check("sp_next", {29'd0, dbg_state}, {29'd0, S_NEXT});
    step();
    check("sp_fin_odone", {31'd0, sif.odone}, 32'd1);
    check("sp_fin_oerr", {31'd0, sif.oerr}, 32'd0);
    step();
    check("sp_idle", {31'd0, sif.obusy}, 32'd0);

    // Reset during DRV_WAIT of block 1 of 4
    start_job(16'd4);
    step();
    sif.idone_d = 1'b1;
    step();
    clear_inputs();
    step();
    sif.idone_p = 1'b1;
    step();
    sif.idone_p = 1'b0;
    step();
    check("rst_blk1_drv_go", {31'd0, sif.ostart_d}, 32'd1);
    step();
    check("rst_blk1_wait", {29'd0, dbg_state}, {29'd0, S_DRV_WAIT});
    check("rst_blk1_idx", {16'd0, sif.oblk_idx}, 32'd1);
    #2;
    irst = 1'b0;
    #1;
    check("rst_mid_outputs", all_outs(), 32'd0);
    check("rst_mid_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    step();
    irst = 1'b1;
    step();
    check("rst_release_outputs", all_outs(), 32'd0);
    apply_vec('{nb: 16'd2, fail_n: 0, exp_sd: 2, exp_sp: 2, exp_err: 1'b0, exp_idx: 16'd1}, "restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
